// File: rtl/aes_dec_pkg.sv
// Shared types, widths and GF(2^8) helpers for the AES decryption round controller.
package aes_dec_pkg;

    localparam int AES_BLOCK_W   = 128;
    localparam int AES128_ROUNDS = 10;
    localparam int KEY_IDX_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } dec_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), with 0 mapping to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < 6; i++) begin
            r = gf_mul(gf_mul(r, r), a);
        end
        return gf_mul(r, r);
    endfunction

    // Inverse S-box: undo the affine map, then invert in the field.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] a;
        a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(a);
    endfunction

endpackage

// File: rtl/aes_dec_round_ctrl_one_round.sv
// Single inverse-cipher round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the final round (round number 0).
module One_Round_Dec
    import aes_dec_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] i_Din,
    input  logic [KEY_IDX_W-1:0]   i_Round_Times,
    input  logic [AES_BLOCK_W-1:0] i_Round_key,
    output logic [AES_BLOCK_W-1:0] o_Dout
);

    logic [7:0] sub_b [16];
    logic [7:0] mix_b [16];

    genvar gi;
    generate
        // Byte gi = row + 4*col; row r is rotated right by r positions.
        for (gi = 0; gi < 16; gi++) begin : g_byte
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = ROW + 4 * ((COL + 4 - ROW) % 4);
            assign sub_b[gi] = inv_sbox(i_Din[AES_BLOCK_W-1-8*SRC -: 8])
                             ^ i_Round_key[AES_BLOCK_W-1-8*gi -: 8];
        end

        for (gi = 0; gi < 4; gi++) begin : g_col
            assign mix_b[4*gi+0] = gf_mul(sub_b[4*gi+0], 8'h0e) ^ gf_mul(sub_b[4*gi+1], 8'h0b)
                                 ^ gf_mul(sub_b[4*gi+2], 8'h0d) ^ gf_mul(sub_b[4*gi+3], 8'h09);
            assign mix_b[4*gi+1] = gf_mul(sub_b[4*gi+0], 8'h09) ^ gf_mul(sub_b[4*gi+1], 8'h0e)
                                 ^ gf_mul(sub_b[4*gi+2], 8'h0b) ^ gf_mul(sub_b[4*gi+3], 8'h0d);
            assign mix_b[4*gi+2] = gf_mul(sub_b[4*gi+0], 8'h0d) ^ gf_mul(sub_b[4*gi+1], 8'h09)
                                 ^ gf_mul(sub_b[4*gi+2], 8'h0e) ^ gf_mul(sub_b[4*gi+3], 8'h0b);
            assign mix_b[4*gi+3] = gf_mul(sub_b[4*gi+0], 8'h0b) ^ gf_mul(sub_b[4*gi+1], 8'h0d)
                                 ^ gf_mul(sub_b[4*gi+2], 8'h09) ^ gf_mul(sub_b[4*gi+3], 8'h0e);
        end

        for (gi = 0; gi < 16; gi++) begin : g_out
            assign o_Dout[AES_BLOCK_W-1-8*gi -: 8] = (i_Round_Times == '0) ? sub_b[gi] : mix_b[gi];
        end
    endgenerate

endmodule

// File: rtl/aes_dec_round_ctrl.sv
// Iterative AES decryption controller: one round per clock, round keys fetched by index.
// Optional AES_DEC_ABORT_EN adds i_Abort, which returns the block to IDLE on the next edge.
module aes_dec_round_ctrl
    import aes_dec_pkg::*;
#(
    parameter int P_ROUNDS = AES128_ROUNDS
)
(
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    input  logic [AES_BLOCK_W-1:0] i_Din,
    input  logic                   i_Din_Valid,
    output logic                   o_Din_Ready,
    output logic [KEY_IDX_W-1:0]   o_Key_Idx,
    input  logic [AES_BLOCK_W-1:0] i_Round_Key,
    output logic [AES_BLOCK_W-1:0] o_Dout,
    output logic                   o_Dout_Valid,
    input  logic                   i_Dout_Ready,
    output logic                   o_Busy
`ifdef AES_DEC_ABORT_EN
    ,
    input  logic                   i_Abort
`endif
);

    localparam logic [KEY_IDX_W-1:0] LAST_KEY  = KEY_IDX_W'(P_ROUNDS);
    localparam logic [KEY_IDX_W-1:0] FIRST_CNT = KEY_IDX_W'(P_ROUNDS - 1);
    localparam logic [KEY_IDX_W-1:0] CNT_STEP  = 1;

    dec_state_e             fsm_reg, fsm_next;
    logic [KEY_IDX_W-1:0]   cnt_reg, cnt_next;
    logic [AES_BLOCK_W-1:0] blk_reg, blk_next;
    logic [AES_BLOCK_W-1:0] round_out;

    One_Round_Dec u_round (
        .i_Din         (blk_reg),
        .i_Round_Times (cnt_reg),
        .i_Round_key   (i_Round_Key),
        .o_Dout        (round_out)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            fsm_reg <= ST_IDLE;
            cnt_reg <= '0;
            blk_reg <= '0;
        end else begin
            fsm_reg <= fsm_next;
            cnt_reg <= cnt_next;
            blk_reg <= blk_next;
        end
    end

    always_comb begin
        fsm_next     = fsm_reg;
        cnt_next     = cnt_reg;
        blk_next     = blk_reg;
        o_Din_Ready  = 1'b0;
        o_Key_Idx    = cnt_reg;
        o_Dout_Valid = 1'b0;
        o_Busy       = 1'b1;

        case (fsm_reg)
            ST_IDLE: begin
                o_Din_Ready = 1'b1;
                o_Busy      = 1'b0;
                o_Key_Idx   = LAST_KEY;
                if (i_Din_Valid) begin
                    blk_next = i_Din ^ i_Round_Key;
                    cnt_next = FIRST_CNT;
                    fsm_next = ST_ROUND;
                end
            end
            ST_ROUND: begin
                blk_next = round_out;
                // Round 0 is the final round; leaving on 0 keeps the counter from wrapping.
                if (cnt_reg == '0) begin
                    fsm_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg - CNT_STEP;
                end
            end
            ST_DONE: begin
                o_Dout_Valid = 1'b1;
                if (i_Dout_Ready) begin
                    fsm_next = ST_IDLE;
                end
            end
            default: begin
                fsm_next = ST_IDLE;
            end
        endcase

`ifdef AES_DEC_ABORT_EN
        if (i_Abort) begin
            fsm_next = ST_IDLE;
            cnt_next = '0;
            blk_next = '0;
        end
`endif
    end

    assign o_Dout = o_Dout_Valid ? blk_reg : '0;

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Self-checking bench for aes_dec_round_ctrl: FIPS-197 vectors plus random blocks
// encrypted by a forward-cipher reference model kept in this file.
module tb_aes_dec_round_ctrl;

    logic         clk;
    logic         rst_n;
    logic [127:0] din;
    logic         din_valid;
    logic         din_ready;
    logic [3:0]   key_idx;
    logic [127:0] round_key;
    logic [127:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         busy;
`ifdef AES_DEC_ABORT_EN
    logic         abort;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox [256];
    logic [127:0] rk [16];

    assign round_key = rk[key_idx];

    aes_dec_round_ctrl dut (
        .i_Clk        (clk),
        .i_Rst_n      (rst_n),
        .i_Din        (din),
        .i_Din_Valid  (din_valid),
        .o_Din_Ready  (din_ready),
        .o_Key_Idx    (key_idx),
        .i_Round_Key  (round_key),
        .o_Dout       (dout),
        .o_Dout_Valid (dout_valid),
        .i_Dout_Ready (dout_ready),
        .o_Busy       (busy)
`ifdef AES_DEC_ABORT_EN
        ,
        .i_Abort      (abort)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        int           hold;
        string        name;
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (forward AES-128) ----------------
    function automatic logic [7:0] bmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        logic [7:0] y;
        r = 0; x = a; y = b;
        while (y != 0) begin
            if (y[0]) r = r ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return r;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] b;
            inv = 0;
            for (int y = 1; y < 256; y++) begin
                if (bmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x] = b;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = bmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                if (r != 10) begin
                    s[4*c+0] = bmul(t[4*c], 2) ^ bmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ bmul(t[4*c+1], 2) ^ bmul(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ bmul(t[4*c+2], 2) ^ bmul(t[4*c+3], 3);
                    s[4*c+3] = bmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ bmul(t[4*c+3], 2);
                end else begin
                    for (int k = 0; k < 4; k++) s[4*c+k] = t[4*c+k];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Called at a negedge in IDLE; returns at the negedge after the accepting edge, valid still high.
    task automatic accept(input logic [127:0] ct, input string tag);
        chk({tag, " idle ready"}, 128'(din_ready), 128'(1));
        chk({tag, " idle key_idx"}, 128'(key_idx), 128'(10));
        din       = ct;
        din_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Accept edge counts as edge 1; the block must present its result after edge 11.
    task automatic await_done(input logic [127:0] exp, input string tag);
        int edges;
        int exp_idx;
        edges   = 1;
        exp_idx = 9;
        while (dout_valid !== 1'b1 && edges < 40) begin
            chk({tag, " key_idx"}, 128'(key_idx), 128'(exp_idx));
            chk({tag, " busy"}, 128'(busy), 128'(1));
            chk({tag, " din_ready"}, 128'(din_ready), 128'(0));
            chk({tag, " dout masked"}, dout, '0);
            exp_idx--;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk({tag, " latency"}, 128'(edges), 128'(11));
        chk({tag, " dout"}, dout, exp);
        $display("txn %s: dout=%h edges=%0d", tag, dout, edges);
    endtask

    task automatic release_out(input logic [127:0] exp, input int hold, input string tag);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, " hold dout"}, dout, exp);
            chk({tag, " hold valid"}, 128'(dout_valid), 128'(1));
            chk({tag, " hold din_ready"}, 128'(din_ready), 128'(0));
        end
        dout_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dout_ready = 1'b0;
        chk({tag, " post busy"}, 128'(busy), 128'(0));
        chk({tag, " post valid"}, 128'(dout_valid), 128'(0));
        chk({tag, " post dout"}, dout, '0);
    endtask

    task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input int hold, input string tag);
        accept(ct, tag);
        din_valid = 1'b0;
        await_done(pt, tag);
        release_out(pt, hold, tag);
    endtask

    task automatic step_to_idx(input int idx, input string tag);
        int n;
        n = 0;
        while (key_idx != 4'(idx) && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk({tag, " reach idx"}, 128'(key_idx), 128'(idx));
    endtask

    initial begin
        logic [127:0] k, pa, pb, ca, cb;

        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    128'h00112233445566778899aabbccddeeff, 5, "fips_c1"};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                    128'h3243f6a8885a308d313198a2e0370734, 0, "fips_b"};
        vecs[2] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, 2, "zero"};

        rst_n      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
`ifdef AES_DEC_ABORT_EN
        abort      = 1'b0;
`endif
        build_sbox();
        expand_key(vecs[0].key);

        repeat (2) @(negedge clk);
        chk("reset busy", 128'(busy), 128'(0));
        chk("reset din_ready", 128'(din_ready), 128'(1));
        chk("reset key_idx", 128'(key_idx), 128'(10));
        chk("reset valid", 128'(dout_valid), 128'(0));
        chk("reset dout", dout, '0);
        rst_n = 1'b1;

        // Table vectors; the first is accepted on the edge right after reset release.
        for (int v = 0; v < 3; v++) begin
            expand_key(vecs[v].key);
            run_block(vecs[v].ct, vecs[v].pt, vecs[v].hold, vecs[v].name);
        end

        // Back-to-back: valid held high across the handshake.
        k  = {$urandom, $urandom, $urandom, $urandom};
        pa = {$urandom, $urandom, $urandom, $urandom};
        pb = {$urandom, $urandom, $urandom, $urandom};
        expand_key(k);
        ca = encrypt(pa);
        cb = encrypt(pb);
        accept(ca, "b2b_a");
        din = cb;
        await_done(pa, "b2b_a");
        dout_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dout_ready = 1'b0;
        chk("b2b handshake busy", 128'(busy), 128'(0));
        chk("b2b handshake din_ready", 128'(din_ready), 128'(1));
        chk("b2b handshake valid", 128'(dout_valid), 128'(0));
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        chk("b2b second accepted", 128'(busy), 128'(1));
        await_done(pb, "b2b_b");
        release_out(pb, 0, "b2b_b");

        // Reset while the counter is 5, then a clean block.
        accept(ca, "rst_mid");
        din_valid = 1'b0;
        step_to_idx(5, "rst_mid");
        rst_n = 1'b0;
        #1;
        chk("rst_mid busy", 128'(busy), 128'(0));
        chk("rst_mid din_ready", 128'(din_ready), 128'(1));
        chk("rst_mid key_idx", 128'(key_idx), 128'(10));
        chk("rst_mid valid", 128'(dout_valid), 128'(0));
        chk("rst_mid dout", dout, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_block(cb, pb, 1, "after_rst");

`ifdef AES_DEC_ABORT_EN
        begin
            int seen;
            accept(ca, "abort");
            din_valid = 1'b0;
            step_to_idx(3, "abort");
            abort = 1'b1;
            @(posedge clk);
            @(negedge clk);
            abort = 1'b0;
            chk("abort busy", 128'(busy), 128'(0));
            chk("abort din_ready", 128'(din_ready), 128'(1));
            seen = 0;
            for (int c = 0; c < 14; c++) begin
                if (dout_valid) seen++;
                @(posedge clk);
                @(negedge clk);
            end
            chk("abort valid never", 128'(seen), 128'(0));
            run_block(ca, pa, 0, "after_abort");
        end
`endif

        // Random blocks against the forward-cipher model.
        for (int r = 0; r < 6; r++) begin
            k  = {$urandom, $urandom, $urandom, $urandom};
            pa = {$urandom, $urandom, $urandom, $urandom};
            expand_key(k);
            ca = encrypt(pa);
            run_block(ca, pa, int'($urandom_range(0, 3)), $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
